// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and sequencer for the single-port data SRAM
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req/we/addr/wdata[0|1]       per-port access request, held stable until granted
//   gnt0/gnt1                    one-cycle grant; the SRAM command is on the bus that cycle
//   rvalid0/rvalid1, rdata0/1    read response, three cycles after the request
//   CEN/WEN/OEN/A/D/Q            SRAM command bus (registered) and read data
//   conflict_cnt                 saturating count of cycles with both ports requesting
module dmem_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q,
  output logic [15:0]   conflict_cnt
);

  logic          ptr;      // round-robin pointer: port that wins the next tie
  logic          s1_valid;
  logic          s1_tag;
  logic          s2_valid;
  logic          s2_tag;

  logic          both;
  logic          any_req;
  logic          winner;   // 0 = port 0, 1 = port 1
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign OEN = 1'b0;

  always_comb begin
    both    = req0 & req1;
    any_req = req0 | req1;
    winner  = 1'b0;
    if (both) begin
      winner = (PRIO_MODE != 0) ? 1'b0 : ptr;
    end else if (req1) begin
      winner = 1'b1;
    end
    win_we    = winner ? we1    : we0;
    win_addr  = winner ? addr1  : addr0;
    win_wdata = winner ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CEN          <= 1'b1;
      WEN          <= 1'b1;
      A            <= '0;
      D            <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      ptr          <= 1'b0;
      s1_valid     <= 1'b0;
      s1_tag       <= 1'b0;
      s2_valid     <= 1'b0;
      s2_tag       <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      conflict_cnt <= '0;
    end else begin
      gnt0 <= any_req & ~winner;
      gnt1 <= any_req & winner;

      // Idle cycles keep A/D unchanged to avoid toggling the SRAM bus.
      if (any_req) begin
        CEN <= 1'b0;
        WEN <= ~win_we;
        A   <= win_addr;
        D   <= win_we ? win_wdata : '0;
      end else begin
        CEN <= 1'b1;
        WEN <= 1'b1;
      end

      if (both && PRIO_MODE == 0) begin
        ptr <= ~winner;
      end

      // s1: command on the bus; s2: SRAM is producing Q; output stage samples Q.
      s1_valid <= any_req & ~win_we;
      s1_tag   <= winner;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;

      rvalid0 <= s2_valid & ~s2_tag;
      rvalid1 <= s2_valid & s2_tag;
      if (s2_valid && !s2_tag) begin
        rdata0 <= Q;
      end
      if (s2_valid && s2_tag) begin
        rdata1 <= Q;
      end

      if (both && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter in round-robin and fixed-priority modes
module tb_dmem_arbiter;

  localparam logic [31:0] D1 = 32'h1111_0001;
  localparam logic [31:0] D2 = 32'h2222_0002;

  typedef struct {
    logic        tag;
    logic [31:0] data;
  } rsp_t;

  rsp_t qa[$];
  rsp_t qb[$];

  int vectors = 0;
  int miscompares = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;

  // instance a: round-robin, instance b: fixed priority
  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_CEN, a_WEN, a_OEN;
  logic [31:0] a_rdata0, a_rdata1, a_D, a_Q;
  logic [6:0]  a_A;
  logic [15:0] a_cnt;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_CEN, b_WEN, b_OEN;
  logic [31:0] b_rdata0, b_rdata1, b_D, b_Q;
  logic [6:0]  b_A;
  logic [15:0] b_cnt;

  logic [31:0] ma [0:127];
  logic [31:0] mb [0:127];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(7), .DW(32), .PRIO_MODE(0)) u_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1),
    .CEN(a_CEN), .WEN(a_WEN), .OEN(a_OEN), .A(a_A), .D(a_D), .Q(a_Q),
    .conflict_cnt(a_cnt)
  );

  dmem_arbiter #(.AW(7), .DW(32), .PRIO_MODE(1)) u_b (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1),
    .CEN(b_CEN), .WEN(b_WEN), .OEN(b_OEN), .A(b_A), .D(b_D), .Q(b_Q),
    .conflict_cnt(b_cnt)
  );

  // Synchronous single-port SRAM models: Q valid the cycle after the command.
  always @(posedge clk) begin
    if (!a_CEN) begin
      if (!a_WEN) ma[a_A] <= a_D;
      else        a_Q <= ma[a_A];
    end
    if (!b_CEN) begin
      if (!b_WEN) mb[b_A] <= b_D;
      else        b_Q <= mb[b_A];
    end
  end

  // Response scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    rsp_t e;
    if (a_rvalid0 && a_rvalid1) begin
      miscompares++;
      $display("FAIL a_rvalid_excl: both rvalid high, required one-hot");
    end
    if (a_rvalid0 || a_rvalid1) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL a_rsp_unexpected: got rvalid tag %0d, required none", a_rvalid1);
      end else begin
        e = qa.pop_front();
        if (a_rvalid1 !== e.tag || (a_rvalid1 ? a_rdata1 : a_rdata0) !== e.data) begin
          miscompares++;
          $display("FAIL a_rsp: got tag %0d data %h, required tag %0d data %h",
                   a_rvalid1, a_rvalid1 ? a_rdata1 : a_rdata0, e.tag, e.data);
        end
      end
    end
    if (b_rvalid0 || b_rvalid1) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL b_rsp_unexpected: got rvalid tag %0d, required none", b_rvalid1);
      end else begin
        e = qb.pop_front();
        if (b_rvalid1 !== e.tag || (b_rvalid1 ? b_rdata1 : b_rdata0) !== e.data) begin
          miscompares++;
          $display("FAIL b_rsp: got tag %0d data %h, required tag %0d data %h",
                   b_rvalid1, b_rvalid1 ? b_rdata1 : b_rdata0, e.tag, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 7'h00; addr1 = 7'h00; wdata0 = 32'h0; wdata1 = 32'h0;
    cyc(); cyc();
    vectors++;
    if ({a_CEN, a_WEN, a_OEN, a_gnt0, a_gnt1, a_rvalid0, a_rvalid1} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 1100000",
               {a_CEN, a_WEN, a_OEN, a_gnt0, a_gnt1, a_rvalid0, a_rvalid1});
    end
    vectors++;
    if (a_cnt !== 16'h0 || a_A !== 7'h0 || a_D !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got cnt %h A %h D %h, required 0 0 0", a_cnt, a_A, a_D);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if (a_gnt0 !== 1'b1 || a_gnt1 !== 1'b0 || a_CEN !== 1'b0 || a_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_first_gnt: got gnt %b%b CEN %b cnt %0d, required gnt 10 CEN 0 cnt 1",
               a_gnt0, a_gnt1, a_CEN, a_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_single_write_read();
    apply_reset();
    req1 = 1'b1; we1 = 1'b1; addr1 = 7'h05; wdata1 = 32'hDEADBEEF;
    cyc();
    vectors++;
    if (a_gnt1 !== 1'b1 || a_gnt0 !== 1'b0 || a_CEN !== 1'b0 || a_WEN !== 1'b0 ||
        a_A !== 7'h05 || a_D !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_cmd: got gnt %b%b CEN %b WEN %b A %h D %h, required 01 0 0 05 deadbeef",
               a_gnt0, a_gnt1, a_CEN, a_WEN, a_A, a_D);
    end
    we1 = 1'b0;
    cyc();
    qa.push_back('{1'b1, 32'hDEADBEEF});
    qb.push_back('{1'b1, 32'hDEADBEEF});
    vectors++;
    if (a_gnt1 !== 1'b1 || a_WEN !== 1'b1 || a_A !== 7'h05 || a_D !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_cmd: got gnt1 %b WEN %b A %h D %h, required 1 1 05 0",
               a_gnt1, a_WEN, a_A, a_D);
    end
    req1 = 1'b0;
    cyc();
    vectors++;
    if (a_rvalid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_early: got rvalid1 %b two cycles after req, required 0", a_rvalid1);
    end
    cyc();
    vectors++;
    if (a_rvalid1 !== 1'b1 || a_rdata1 !== 32'hDEADBEEF || a_rvalid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_latency: got rvalid %b%b rdata1 %h, required 01 deadbeef",
               a_rvalid0, a_rvalid1, a_rdata1);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp;
    apply_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h01; wdata0 = D1;
    cyc();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 7'h02; wdata1 = D2;
    cyc();
    req0 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp = i[0];
      qa.push_back('{exp, exp ? D2 : D1});
      qb.push_back('{1'b0, D1});
      vectors++;
      if (a_gnt0 !== ~exp || a_gnt1 !== exp) begin
        miscompares++;
        $display("FAIL rr_gnt[%0d]: got gnt %b%b, required %b%b", i, a_gnt0, a_gnt1, ~exp, exp);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (a_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL rr_conflict_cnt: got %0d, required 6", a_cnt);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 7'h01; addr1 = 7'h02;
    for (int i = 0; i < 4; i++) begin
      cyc();
      qb.push_back('{1'b0, D1});
      qa.push_back('{i[0], i[0] ? D2 : D1});
      vectors++;
      if (b_gnt0 !== 1'b1 || b_gnt1 !== 1'b0) begin
        miscompares++;
        $display("FAIL fp_gnt[%0d]: got gnt %b%b, required 10", i, b_gnt0, b_gnt1);
      end
    end
    req0 = 1'b0;
    cyc();
    qb.push_back('{1'b1, D2});
    qa.push_back('{1'b1, D2});
    req1 = 1'b0;
    vectors++;
    if (b_gnt1 !== 1'b1 || b_gnt0 !== 1'b0 || b_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL fp_release: got gnt %b%b cnt %0d, required 01 cnt 4", b_gnt0, b_gnt1, b_cnt);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h01;
    cyc();
    vectors++;
    if (a_gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL mf_gnt0: got %b, required 1", a_gnt0);
    end
    req0 = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if ({a_CEN, a_WEN, a_gnt0, a_gnt1, a_rvalid0, a_rvalid1} !== 6'b110000 ||
        a_A !== 7'h0 || a_D !== 32'h0 || a_rdata0 !== 32'h0 || a_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL mf_reset_vals: got ctrl %b A %h D %h rdata0 %h cnt %h, required 110000 0 0 0 0",
               {a_CEN, a_WEN, a_gnt0, a_gnt1, a_rvalid0, a_rvalid1}, a_A, a_D, a_rdata0, a_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++;
      if (a_rvalid0 !== 1'b0 || b_rvalid0 !== 1'b0) begin
        miscompares++;
        $display("FAIL mf_dropped[%0d]: got rvalid0 a %b b %b, required 0 0", i, a_rvalid0, b_rvalid0);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; addr0 = 7'h10; addr1 = 7'h11;
    repeat (65534) cyc();
    vectors++;
    if (a_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_pre: got %h, required fffe", a_cnt);
    end
    repeat (6) cyc();
    vectors++;
    if (a_cnt !== 16'hFFFF || b_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got a %h b %h, required ffff ffff", a_cnt, b_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write_read();
    test_round_robin();
    test_fixed_priority();
    test_reset_midflight();
    test_saturation();
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_outstanding: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
